regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 106 ++++++++++
 tb/tb_regfile_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: NREAD combinational read ports, one synchronous write port,
// hardwired-zero entry, optional write-to-read bypass and a post-reset index-fill sequencer.
module regfile_param #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = NREGS - 1,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we3,
    input  logic [AW-1:0]          wa3,
    input  logic [WIDTH-1:0]       wd3,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic                   ready
);

    // One extra bit so the range check also works when NREGS is a power of two.
    localparam logic [AW:0]   NumRegsExt = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] ZeroIdx    = AW'(ZERO_REG);
    localparam logic [AW-1:0] LastIdx    = AW'(NREGS - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] mem_q [NREGS];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    ra_idx [NREAD];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        wr_addr = wa3;
        wr_data = wd3;
        unique case (state_q)
            StInit: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = (cnt_q == ZeroIdx) ? '0 : WIDTH'(cnt_q);
                if (cnt_q == LastIdx) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            StRun: begin
                // An unknown we3 falls through to no write.
                if (we3 && (wa3 != ZeroIdx) && ({1'b0, wa3} < NumRegsExt)) begin
                    wr_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREAD); i++) begin
            ra_idx[i] = ra[i*AW +: AW];
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            if (ready_q && (ra_idx[i] != ZeroIdx) && ({1'b0, ra_idx[i]} < NumRegsExt)) begin
                // ra_idx is known non-zero-reg here, so a matching wa3 is too.
                if (BYPASS && we3 && (wa3 == ra_idx[i])) begin
                    rd[i*WIDTH +: WIDTH] = wd3;
                end else begin
                    rd[i*WIDTH +: WIDTH] = mem_q[ra_idx[i]];
                end
            end
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, bypass/3-port and non-power-of-two instances.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: defaults (WIDTH=64, NREGS=32, NREAD=2, BYPASS=0)
    logic         rst_a = 1'b1;
    logic         we_a  = 1'b0;
    logic [4:0]   wa_a  = '0;
    logic [63:0]  wd_a  = '0;
    logic [9:0]   ra_a  = '0;
    logic [127:0] rd_a;
    logic         rdy_a;

    // B: bypass, three read ports
    logic         rst_bc = 1'b1;
    logic         we_b   = 1'b0;
    logic [4:0]   wa_b   = '0;
    logic [63:0]  wd_b   = '0;
    logic [14:0]  ra_b   = '0;
    logic [191:0] rd_b;
    logic         rdy_b;

    // C: 24 entries, 32-bit words
    logic         we_c = 1'b0;
    logic [4:0]   wa_c = '0;
    logic [31:0]  wd_c = '0;
    logic [9:0]   ra_c = '0;
    logic [63:0]  rd_c;
    logic         rdy_c;

    regfile_param u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .we3   (we_a),
        .wa3   (wa_a),
        .wd3   (wd_a),
        .ra    (ra_a),
        .rd    (rd_a),
        .ready (rdy_a)
    );

    regfile_param #(
        .NREAD  (3),
        .BYPASS (1'b1)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_bc),
        .we3   (we_b),
        .wa3   (wa_b),
        .wd3   (wd_b),
        .ra    (ra_b),
        .rd    (rd_b),
        .ready (rdy_b)
    );

    regfile_param #(
        .WIDTH    (32),
        .NREGS    (24),
        .ZERO_REG (23)
    ) u_dut_c (
        .clk   (clk),
        .reset (rst_bc),
        .we3   (we_c),
        .wa3   (wa_c),
        .wd3   (wd_c),
        .ra    (ra_c),
        .rd    (rd_c),
        .ready (rdy_c)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready_a rises; gives up after 64.
    task automatic wait_ready_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy_a && n < 64);
    endtask

    int n;

    initial begin
        tv[0] = '{1'b0, 5'd0,  64'd0,                  5'd5,  5'd30, 64'd5,  64'd30};
        tv[1] = '{1'b0, 5'd0,  64'd0,                  5'd31, 5'd0,  64'd0,  64'd0};
        tv[2] = '{1'b1, 5'd7,  64'hDEADBEEF_00000001,  5'd7,  5'd7,  64'd7,  64'd7};
        tv[3] = '{1'b0, 5'd0,  64'd0,                  5'd7,  5'd6,  64'hDEADBEEF_00000001, 64'd6};
        tv[4] = '{1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF,  5'd31, 5'd7,  64'd0,  64'hDEADBEEF_00000001};
        tv[5] = '{1'b0, 5'd0,  64'd0,                  5'd31, 5'd31, 64'd0,  64'd0};
        tv[6] = '{1'b1, 5'd0,  64'h1234,               5'd0,  5'd1,  64'd0,  64'd1};
        tv[7] = '{1'b1, 5'd1,  64'h5678,               5'd0,  5'd1,  64'h1234, 64'd1};
        tv[8] = '{1'b0, 5'd0,  64'd0,                  5'd1,  5'd0,  64'h5678, 64'h1234};
        tv[9] = '{1'b0, 5'd0,  64'd0,                  5'd30, 5'd29, 64'd30, 64'd29};

        // Reset held for three edges
        ra_a = {5'd5, 5'd3};
        tick();
        tick();
        tick();
        chk("rst_ready_a", {63'd0, rdy_a}, 64'd0);
        chk("rst_rd_a", {63'd0, |rd_a}, 64'd0);
        chk("rst_ready_b", {63'd0, rdy_b}, 64'd0);

        rst_a  = 1'b0;
        rst_bc = 1'b0;
        wait_ready_a(n);
        chk("init_latency_a", 64'(n), 64'd32);
        chk("ready_b", {63'd0, rdy_b}, 64'd1);
        chk("ready_c", {63'd0, rdy_c}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            we_a = tv[i].we;
            wa_a = tv[i].wa;
            wd_a = tv[i].wd;
            ra_a = {tv[i].ra1, tv[i].ra0};
            #1;
            chk($sformatf("vec_a[%0d].rd0", i), rd_a[63:0], tv[i].exp0);
            chk($sformatf("vec_a[%0d].rd1", i), rd_a[127:64], tv[i].exp1);
            tick();
        end
        we_a = 1'b0;

        // Unknown write enable must not write
        we_a = 1'bx;
        wa_a = 5'd3;
        wd_a = 64'h55;
        ra_a = {5'd3, 5'd3};
        #1;
        chk("x_we_same", rd_a[63:0], 64'd3);
        tick();
        we_a = 1'b0;
        #1;
        chk("x_we_after", rd_a[63:0], 64'd3);

        // Reset mid-init at cnt=10, writes attempted during INIT
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_a = 1'b1;
        tick();
        chk("midinit_ready", {63'd0, rdy_a}, 64'd0);
        rst_a = 1'b0;
        we_a  = 1'b1;
        wa_a  = 5'd2;
        wd_a  = 64'd99;
        wait_ready_a(n);
        chk("midinit_latency", 64'(n), 64'd32);
        we_a = 1'b0;
        ra_a = {5'd7, 5'd2};
        #1;
        chk("midinit_reg2", rd_a[63:0], 64'd2);
        chk("midinit_reg7", rd_a[127:64], 64'd7);

        // Bypass instance
        we_b = 1'b1;
        wa_b = 5'd4;
        wd_b = 64'hAA;
        ra_b = {5'd4, 5'd4, 5'd4};
        #1;
        for (int p = 0; p < 3; p++) chk($sformatf("byp_same[%0d]", p), rd_b[p*64 +: 64], 64'hAA);
        tick();
        for (int p = 0; p < 3; p++) chk($sformatf("byp_next[%0d]", p), rd_b[p*64 +: 64], 64'hAA);
        wd_b = 64'hCC;
        ra_b = {5'd5, 5'd4, 5'd4};
        #1;
        chk("byp_fwd", rd_b[63:0], 64'hCC);
        chk("byp_other", rd_b[191:128], 64'd5);
        tick();
        we_b = 1'b0;
        #1;
        chk("byp_stored", rd_b[127:64], 64'hCC);
        we_b = 1'b1;
        wa_b = 5'd31;
        wd_b = 64'hBB;
        ra_b = {5'd31, 5'd31, 5'd31};
        #1;
        for (int p = 0; p < 3; p++) chk($sformatf("byp_zero_same[%0d]", p), rd_b[p*64 +: 64], 64'd0);
        tick();
        for (int p = 0; p < 3; p++) chk($sformatf("byp_zero_next[%0d]", p), rd_b[p*64 +: 64], 64'd0);
        we_b = 1'b0;

        // Non-power-of-two instance
        ra_c = {5'd23, 5'd20};
        #1;
        chk("np2_ra20", {32'd0, rd_c[31:0]}, 64'd20);
        chk("np2_ra23", {32'd0, rd_c[63:32]}, 64'd0);
        ra_c = {5'd0, 5'd30};
        #1;
        chk("np2_ra30", {32'd0, rd_c[31:0]}, 64'd0);
        chk("np2_ra0", {32'd0, rd_c[63:32]}, 64'd0);
        we_c = 1'b1;
        wa_c = 5'd30;
        wd_c = 32'hFFFF_FFFF;
        tick();
        we_c = 1'b0;
        for (int i = 0; i < 23; i++) begin
            ra_c = {5'(22 - i), 5'(i)};
            #1;
            chk($sformatf("np2_entry[%0d]", i), {32'd0, rd_c[31:0]}, 64'(i));
            chk($sformatf("np2_entry_rev[%0d]", i), {32'd0, rd_c[63:32]}, 64'(22 - i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
